lutram_fifo_controller: RTL and testbench

Synchronous FIFO control stage that sits directly upstream of a dual_port_lutram instance and drives both of its ports. It manages the write and read pointers and the full/empty state, hides the LUTRAM's 1-cycle read latency behind a 2-entry output skid buffer, and presents valid/ready handshakes on both the producer and consumer sides. Total capacity is NUM_SET LUTRAM entries plus 2 skid entries.

---
 rtl/lutram_fifo_controller.sv | 138 +++++++++++++
 tb/tb_lutram_fifo_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lutram_fifo_controller.sv
// FIFO control stage in front of a dual-port LUTRAM: pointer/occupancy management,
// prefetch into a 2-entry skid buffer to hide the 1-cycle read latency.
module lutram_fifo_controller #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / 8,
  parameter int COUNT_WIDTH_IN_BITS        = $clog2(NUM_SET + 3)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  request_valid_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
  output logic                                  request_ready_out,
  output logic                                  response_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] response_data_out,
  input  logic                                  response_ready_in,
  output logic                                  write_port_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]             write_port_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_port_access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_out,
  output logic                                  read_port_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_in,
  input  logic                                  read_port_valid_in,
  output logic [COUNT_WIDTH_IN_BITS-1:0]        occupancy_out,
  output logic                                  error_out
);

  localparam int LUT_CNT_W = $clog2(NUM_SET + 1);
  localparam logic [LUT_CNT_W-1:0] LUT_FULL = LUT_CNT_W'(NUM_SET);

  logic [SET_PTR_WIDTH_IN_BITS-1:0]      wptr_r, rptr_r;
  logic [LUT_CNT_W-1:0]                  lut_cnt_r, lut_cnt_next_s;
  logic [1:0]                            skid_cnt_r, skid_cnt_next_s;
  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] skid_head_r, skid_tail_r;
  logic [COUNT_WIDTH_IN_BITS-1:0]        occ_r;
  logic                                  inflight_r, ready_r, valid_r, error_r;
  logic                                  accept_s, issue_s, pop_s, capture_s;

  // Handshake decode; the issue test counts a same-cycle pop as a freed slot so
  // the prefetch keeps pace with a consumer that is always ready.
  always_comb begin
    accept_s  = request_valid_in & ready_r;
    pop_s     = valid_r & response_ready_in;
    capture_s = inflight_r;
    issue_s   = (lut_cnt_r != {LUT_CNT_W{1'b0}}) &&
                (({1'b0, skid_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);
  end

  // Next LUTRAM occupancy and next skid fill level.
  always_comb begin
    lut_cnt_next_s = lut_cnt_r;
    case ({accept_s, issue_s})
      2'b10:   lut_cnt_next_s = lut_cnt_r + LUT_CNT_W'(1);
      2'b01:   lut_cnt_next_s = lut_cnt_r - LUT_CNT_W'(1);
      default: lut_cnt_next_s = lut_cnt_r;
    endcase
    skid_cnt_next_s = skid_cnt_r;
    case ({capture_s, pop_s})
      2'b10:   skid_cnt_next_s = skid_cnt_r + 2'd1;
      2'b01:   skid_cnt_next_s = skid_cnt_r - 2'd1;
      default: skid_cnt_next_s = skid_cnt_r;
    endcase
  end

  // LUTRAM port drive; everything is zero when the port is idle.
  always_comb begin
    write_port_access_en_out       = accept_s;
    write_port_write_en_out        = {WRITE_MASK_LEN{accept_s}};
    write_port_access_set_addr_out = accept_s ? wptr_r : {SET_PTR_WIDTH_IN_BITS{1'b0}};
    write_port_data_out            = accept_s ? request_data_in
                                              : {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
    read_port_access_en_out        = issue_s;
    read_port_access_set_addr_out  = issue_s ? rptr_r : {SET_PTR_WIDTH_IN_BITS{1'b0}};
  end

  // Pointers, counters, ready and the sticky read-error flag.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wptr_r     <= {SET_PTR_WIDTH_IN_BITS{1'b0}};
      rptr_r     <= {SET_PTR_WIDTH_IN_BITS{1'b0}};
      lut_cnt_r  <= {LUT_CNT_W{1'b0}};
      occ_r      <= {COUNT_WIDTH_IN_BITS{1'b0}};
      inflight_r <= 1'b0;
      ready_r    <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      if (accept_s) wptr_r <= wptr_r + SET_PTR_WIDTH_IN_BITS'(1);
      if (issue_s)  rptr_r <= rptr_r + SET_PTR_WIDTH_IN_BITS'(1);
      lut_cnt_r  <= lut_cnt_next_s;
      ready_r    <= (lut_cnt_next_s < LUT_FULL);
      inflight_r <= issue_s;
      error_r    <= error_r | (capture_s & (read_port_valid_in != 1'b1));
      case ({accept_s, pop_s})
        2'b10:   occ_r <= occ_r + COUNT_WIDTH_IN_BITS'(1);
        2'b01:   occ_r <= occ_r - COUNT_WIDTH_IN_BITS'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Two-entry skid buffer; head is always the oldest entry.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      skid_head_r <= {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
      skid_tail_r <= {SINGLE_ENTRY_WIDTH_IN_BITS{1'b0}};
      skid_cnt_r  <= 2'd0;
      valid_r     <= 1'b0;
    end else begin
      skid_cnt_r <= skid_cnt_next_s;
      valid_r    <= (skid_cnt_next_s != 2'd0);
      case ({capture_s, pop_s})
        2'b11: begin
          if (skid_cnt_r == 2'd2) begin
            skid_head_r <= skid_tail_r;
            skid_tail_r <= read_port_data_in;
          end else begin
            skid_head_r <= read_port_data_in;
          end
        end
        2'b10: begin
          if (skid_cnt_r == 2'd0) skid_head_r <= read_port_data_in;
          else                    skid_tail_r <= read_port_data_in;
        end
        2'b01:   skid_head_r <= skid_tail_r;
        default: skid_head_r <= skid_head_r;
      endcase
    end
  end

  assign request_ready_out  = ready_r;
  assign response_valid_out = valid_r;
  assign response_data_out  = skid_head_r;
  assign occupancy_out      = occ_r;
  assign error_out          = error_r;

endmodule

// File: tb/tb_lutram_fifo_controller.sv
// Scoreboard bench for lutram_fifo_controller with a behavioural dual-port LUTRAM.
module tb_lutram_fifo_controller;
  localparam int W  = 64;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int MW = 8;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, rsp_ready;
  logic [W-1:0]  req_data;
  logic          req_ready, rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          wr_en, rd_en;
  logic [MW-1:0] wr_mask;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data = '0;
  logic          rd_valid = 1'b1;
  logic [CW-1:0] occ;
  logic          err;
  logic          force_invalid = 1'b0;

  logic [W-1:0]  mem [N];
  logic [W-1:0]  exp_q [$];
  int checks = 0, errors = 0, cyc_cnt = 0;
  int pop_cnt = 0, first_pop_cyc = 0, last_pop_cyc = 0;

  always #5 clk = ~clk;

  lutram_fifo_controller #(
    .SINGLE_ENTRY_WIDTH_IN_BITS(W), .NUM_SET(N)
  ) dut (
    .clk_in(clk), .reset_in(rst_n),
    .request_valid_in(req_valid), .request_data_in(req_data), .request_ready_out(req_ready),
    .response_valid_out(rsp_valid), .response_data_out(rsp_data), .response_ready_in(rsp_ready),
    .write_port_access_en_out(wr_en), .write_port_write_en_out(wr_mask),
    .write_port_access_set_addr_out(wr_addr), .write_port_data_out(wr_data),
    .read_port_access_en_out(rd_en), .read_port_access_set_addr_out(rd_addr),
    .read_port_data_in(rd_data), .read_port_valid_in(rd_valid),
    .occupancy_out(occ), .error_out(err)
  );

  // Behavioural LUTRAM: registered read, one-cycle latency, optional bad valid flag.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_data  <= mem[rd_addr];
      rd_valid <= ~force_invalid;
    end
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Structural invariants that must hold for any stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (occ <= CW'(N + 2)) else $error("occupancy above capacity: %0d", occ);
      assert (!(wr_en && !req_ready)) else $error("write issued while not ready");
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected-value producer: every accepted request is queued.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && req_valid && req_ready) exp_q.push_back(req_data);
  end

  // Monitor: every presented-and-taken response is compared against the queue head.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
      if (pop_cnt == 0) first_pop_cyc = cyc_cnt;
      last_pop_cyc = cyc_cnt;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got %h expected none", rsp_data);
      end else begin
        check("response_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n, guard;
    rst_n = 1'b0; req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_occ",       64'(occ), 64'd0);
    check("reset_err",       64'(err), 64'd0);
    check("reset_rsp_data",  rsp_data, 64'd0);
    check("reset_wr_port",   64'({wr_en, wr_mask, wr_addr}) | wr_data, 64'd0);
    check("reset_rd_port",   64'({rd_en, rd_addr}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 64'(req_ready), 64'd1);
    check("post_reset_occ",   64'(occ), 64'd0);

    // Single write: visible two edges after the accept edge.
    rsp_ready = 1'b1; req_valid = 1'b1; req_data = 64'hf0f0_f0f0_f0f0_f0f0;
    #1;
    check("single_wr_en",   64'(wr_en), 64'd1);
    check("single_wr_mask", 64'(wr_mask), 64'hff);
    check("single_wr_addr", 64'(wr_addr), 64'd0);
    check("single_wr_data", wr_data, 64'hf0f0_f0f0_f0f0_f0f0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("single_valid_t",  64'(rsp_valid), 64'd0);
    check("single_rd_issue", 64'({rd_en, rd_addr}), 64'h40);
    @(posedge clk); #1;
    check("single_valid_t1", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("single_valid_t2", 64'(rsp_valid), 64'd1);
    check("single_data_t2",  rsp_data, 64'hf0f0_f0f0_f0f0_f0f0);
    @(posedge clk); #1;
    check("single_occ_after", 64'(occ), 64'd0);

    // Fill with consumer stalled: NUM_SET + 2 accepts.
    rsp_ready = 1'b0; n = 0; guard = 0; req_valid = 1'b1; req_data = 64'd0;
    while (n < 66 && guard < 300) begin
      @(negedge clk);
      if (req_ready) n++;
      @(posedge clk); #1;
      req_data = 64'(n);
      guard++;
    end
    req_valid = 1'b0;
    check("fill_accepts", 64'(n), 64'd66);
    repeat (3) @(posedge clk);
    #1;
    check("fill_ready_low", 64'(req_ready), 64'd0);
    check("fill_occ",       64'(occ), 64'd66);
    check("fill_head",      rsp_data, 64'd0);
    rsp_ready = 1'b1;
    drain("fill_drain");
    repeat (2) @(posedge clk);
    #1;
    check("fill_occ_empty", 64'(occ), 64'd0);

    // Streaming 200 words: one word per cycle, pointers wrap three times.
    pop_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      req_valid = 1'b1; req_data = 64'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain("stream_drain");
    check("stream_pops", 64'(pop_cnt), 64'd200);
    check("stream_span", 64'(last_pop_cyc - first_pop_cyc), 64'd199);

    // Random valid/ready traffic.
    n = 0; guard = 0;
    while (n < 300 && guard < 5000) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      req_data  = 64'h5a5a_0000_0000_0000 | 64'(n);
      @(negedge clk);
      if (req_valid && req_ready) n++;
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    check("random_accepts", 64'(n), 64'd300);
    drain("random_drain");
    check("random_no_error", 64'(err), 64'd0);

    // Bad valid flag on one LUTRAM return.
    rsp_ready = 1'b0; req_valid = 1'b1; req_data = 64'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rd_en && guard < 20);
    force_invalid = 1'b1;
    @(posedge clk); #1;
    force_invalid = 1'b0;
    check("err_read_seen", 64'(guard < 20), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("err_set",      64'(err), 64'd1);
    check("err_captured", rsp_data, 64'h1234);
    rsp_ready = 1'b1;
    drain("err_drain");
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 64'(err), 64'd1);

    // Reset with contents held: everything discarded.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_data = 64'(100 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_err_clear", 64'(err), 64'd0);
    check("rst_valid",     64'(rsp_valid), 64'd0);
    check("rst_occ",       64'(occ), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1; req_valid = 1'b1; req_data = 64'hdead_beef;
    @(posedge clk); #1;
    req_valid = 1'b0;
    pop_cnt = 0;
    drain("post_reset_drain");
    check("post_reset_pops", 64'(pop_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
